// File: rtl/isa_fetch_decode_pkg.sv
// Shared types and constants for the instruction fetch/decode front end.
package isa_fetch_decode_pkg;

  localparam int INSTR_W = 16;
  localparam int REG_AW = 5;
  localparam int ALUOP_W = 3;

  localparam int OP1_LSB = 0;
  localparam int OP2_LSB = 5;
  localparam int ALUOP_LSB = 10;
  localparam int WE_BIT = 13;
  localparam int RSVD_BIT = 14;
  localparam int HALT_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    HALTED
  } fsmState_t;

  typedef struct packed {
    logic [REG_AW-1:0] op1;
    logic [REG_AW-1:0] op2;
    logic [ALUOP_W-1:0] aluOp;
    logic weBr;
  } decodedFields_t;

endpackage

// File: rtl/isa_instr_decode.sv
// Splits a 16-bit instruction word into its register/ALU fields and the halt flag.
module isa_instr_decode
  import isa_fetch_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output decodedFields_t     o_fields,
  output logic               o_halt
);

  logic w_reserved;

  assign o_fields.op1 = i_instr[OP1_LSB +: REG_AW];
  assign o_fields.op2 = i_instr[OP2_LSB +: REG_AW];
  assign o_fields.aluOp = i_instr[ALUOP_LSB +: ALUOP_W];
  assign o_fields.weBr = i_instr[WE_BIT];

  // The reserved bit is read so every bit of the word is accounted for, but
  // it is masked off and has no effect on the halt decision.
  assign w_reserved = i_instr[RSVD_BIT];
  assign o_halt = i_instr[HALT_BIT] | (w_reserved & 1'b0);

endmodule

// File: rtl/isa_fetch_decode.sv
// Fetch/decode front end: reads instructions from a synchronous memory, decodes
// them and hands one at a time to the ISA stage over a valid/ready handshake.
module isa_fetch_decode
  import isa_fetch_decode_pkg::*;
#(
  parameter int IMEM_AW = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_rd,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [REG_AW-1:0]  op1,
  output logic [REG_AW-1:0]  op2,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               we_br,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [IMEM_AW-1:0] pc,
  output logic [CNT_W-1:0]   issued_cnt
);

  fsmState_t r_state;
  fsmState_t w_nextState;

  logic [IMEM_AW-1:0] r_pc;
  logic [CNT_W-1:0] r_issuedCnt;
  decodedFields_t r_fields;

  decodedFields_t w_fields;
  logic w_halt;
  logic w_startRun;
  logic w_latch;
  logic w_accept;

  isa_instr_decode u_decode (
    .i_instr  (imem_data),
    .o_fields (w_fields),
    .o_halt   (w_halt)
  );

  // State register; reset drops any in-flight handshake immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the per-state strobes and status outputs.
  always_comb begin
    w_nextState = r_state;
    w_startRun = 1'b0;
    w_latch = 1'b0;
    w_accept = 1'b0;
    imem_rd = 1'b0;
    out_valid = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_startRun = 1'b1;
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        imem_rd = 1'b1;
        busy = 1'b1;
        w_nextState = LATCH;
      end
      LATCH: begin
        busy = 1'b1;
        if (w_halt) begin
          w_nextState = HALTED;
        end else begin
          w_latch = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_accept = 1'b1;
          w_nextState = FETCH;
        end
      end
      HALTED: begin
        done = 1'b1;
        if (start) begin
          w_startRun = 1'b1;
          w_nextState = FETCH;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Program counter, issue counter and the held decoded fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
      r_issuedCnt <= '0;
      r_fields <= '0;
    end else begin
      if (w_startRun) begin
        r_pc <= '0;
        r_issuedCnt <= '0;
      end
      if (w_latch) begin
        r_fields <= w_fields;
        r_pc <= r_pc + 1'b1;
      end
      if (w_accept && (r_issuedCnt != {CNT_W{1'b1}})) begin
        r_issuedCnt <= r_issuedCnt + 1'b1;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc = r_pc;
  assign issued_cnt = r_issuedCnt;
  assign op1 = r_fields.op1;
  assign op2 = r_fields.op2;
  assign alu_op = r_fields.aluOp;
  assign we_br = r_fields.weBr;

endmodule

// File: tb/tb_isa_fetch_decode.sv
// Self-checking bench for isa_fetch_decode: directed steps with a scoreboard of
// expected decoded fields consumed at each downstream handshake.
module tb_isa_fetch_decode;

  typedef struct {
    logic [4:0] op1;
    logic [4:0] op2;
    logic [2:0] aluOp;
    logic weBr;
  } expFields_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic outReady;
  logic imemRd;
  logic [5:0] imemAddr;
  logic [15:0] imemData;
  logic [4:0] op1;
  logic [4:0] op2;
  logic [2:0] aluOp;
  logic weBr;
  logic outValid;
  logic busy;
  logic done;
  logic [5:0] pc;
  logic [15:0] issuedCnt;

  logic startW;
  logic outReadyW;
  logic imemRdW;
  logic [1:0] imemAddrW;
  logic [15:0] imemDataW;
  logic [4:0] op1W;
  logic [4:0] op2W;
  logic [2:0] aluOpW;
  logic weBrW;
  logic outValidW;
  logic busyW;
  logic doneW;
  logic [1:0] pcW;
  logic [15:0] issuedCntW;

  logic [15:0] rom [0:63];
  logic [15:0] romW [0:3];

  expFields_t sbQueue [$];
  expFields_t sbHead;
  expFields_t heldExp;
  expFields_t wrapExp;

  int tests = 0;
  int failures = 0;
  int hsCount = 0;

  isa_fetch_decode dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_rd    (imemRd),
    .imem_addr  (imemAddr),
    .imem_data  (imemData),
    .op1        (op1),
    .op2        (op2),
    .alu_op     (aluOp),
    .we_br      (weBr),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .issued_cnt (issuedCnt)
  );

  isa_fetch_decode #(.IMEM_AW(2), .CNT_W(16)) dutWrap (
    .clk        (clk),
    .rst        (rst),
    .start      (startW),
    .imem_rd    (imemRdW),
    .imem_addr  (imemAddrW),
    .imem_data  (imemDataW),
    .op1        (op1W),
    .op2        (op2W),
    .alu_op     (aluOpW),
    .we_br      (weBrW),
    .out_valid  (outValidW),
    .out_ready  (outReadyW),
    .busy       (busyW),
    .done       (doneW),
    .pc         (pcW),
    .issued_cnt (issuedCntW)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous ROMs: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (imemRd) imemData <= rom[imemAddr];
    if (imemRdW) imemDataW <= romW[imemAddrW];
  end

  // Reference decode written from the field layout using arithmetic.
  function automatic expFields_t modelDecode(input logic [15:0] w);
    expFields_t r;
    int v;
    v = int'(w);
    r.op1 = 5'(v % 32);
    r.op2 = 5'((v / 32) % 32);
    r.aluOp = 3'((v / 1024) % 8);
    r.weBr = 1'((v / 8192) % 2);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit toWrap);
    if (toWrap) startW = 1'b1;
    else start = 1'b1;
    waitCycles(1);
    startW = 1'b0;
    start = 1'b0;
  endtask

  // Scoreboard: every handshake on the main DUT consumes one expected entry.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      hsCount++;
      checkOutput("sb_pending", 32'(sbQueue.size() > 0), 32'd1);
      if (sbQueue.size() > 0) begin
        sbHead = sbQueue.pop_front();
        checkOutput("sb_op1", 32'(op1), 32'(sbHead.op1));
        checkOutput("sb_op2", 32'(op2), 32'(sbHead.op2));
        checkOutput("sb_alu_op", 32'(aluOp), 32'(sbHead.aluOp));
        checkOutput("sb_we_br", 32'(weBr), 32'(sbHead.weBr));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    startW = 1'b0;
    outReady = 1'b0;
    outReadyW = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;

    // Reset state
    waitCycles(2);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_imem_rd", 32'(imemRd), 32'd0);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_cnt", 32'(issuedCnt), 32'd0);
    checkOutput("rst_op1", 32'(op1), 32'd0);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Single instruction followed by halt
    rom[0] = 16'h2C41;
    rom[1] = 16'h8000;
    outReady = 1'b1;
    sbQueue.push_back('{op1: 5'd1, op2: 5'd2, aluOp: 3'd3, weBr: 1'b1});
    applyStimulus(1'b0);
    checkOutput("t1_fetch_rd", 32'(imemRd), 32'd1);
    checkOutput("t1_fetch_addr", 32'(imemAddr), 32'd0);
    checkOutput("t1_fetch_busy", 32'(busy), 32'd1);
    checkOutput("t1_fetch_valid", 32'(outValid), 32'd0);
    waitCycles(1);
    checkOutput("t1_latch_rd", 32'(imemRd), 32'd0);
    checkOutput("t1_latch_valid", 32'(outValid), 32'd0);
    waitCycles(1);
    checkOutput("t1_issue_valid", 32'(outValid), 32'd1);
    checkOutput("t1_op1", 32'(op1), 32'd1);
    checkOutput("t1_op2", 32'(op2), 32'd2);
    checkOutput("t1_alu_op", 32'(aluOp), 32'd3);
    checkOutput("t1_we_br", 32'(weBr), 32'd1);
    waitCycles(1);
    checkOutput("t1_post_valid", 32'(outValid), 32'd0);
    checkOutput("t1_post_cnt", 32'(issuedCnt), 32'd1);
    checkOutput("t1_post_addr", 32'(imemAddr), 32'd1);
    waitCycles(2);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_halt_busy", 32'(busy), 32'd0);
    checkOutput("t1_halt_pc", 32'(pc), 32'd1);
    checkOutput("t1_halt_cnt", 32'(issuedCnt), 32'd1);
    checkOutput("t1_halt_op1", 32'(op1), 32'd1);
    checkOutput("t1_handshakes", 32'(hsCount), 32'd1);
    checkOutput("t1_sb_empty", 32'(sbQueue.size()), 32'd0);

    // Restart from HALTED, ignored start pulses, backpressure
    rom[0] = 16'h5CA9;
    rom[1] = 16'h03E0;
    rom[2] = 16'hC000;
    outReady = 1'b0;
    heldExp = modelDecode(16'h5CA9);
    sbQueue.push_back(heldExp);
    sbQueue.push_back(modelDecode(16'h03E0));
    applyStimulus(1'b0);
    checkOutput("rs_done", 32'(done), 32'd0);
    checkOutput("rs_pc", 32'(pc), 32'd0);
    checkOutput("rs_cnt", 32'(issuedCnt), 32'd0);
    checkOutput("rs_fetch_rd", 32'(imemRd), 32'd1);
    checkOutput("rs_fetch_addr", 32'(imemAddr), 32'd0);
    waitCycles(1);
    applyStimulus(1'b0);
    checkOutput("ign_latch_valid", 32'(outValid), 32'd1);
    checkOutput("ign_latch_pc", 32'(pc), 32'd1);
    checkOutput("ign_latch_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      waitCycles(1);
      start = 1'b0;
      checkOutput("bp_valid", 32'(outValid), 32'd1);
      checkOutput("bp_imem_rd", 32'(imemRd), 32'd0);
      checkOutput("bp_op1", 32'(op1), 32'(heldExp.op1));
      checkOutput("bp_op2", 32'(op2), 32'(heldExp.op2));
      checkOutput("bp_alu_op", 32'(aluOp), 32'(heldExp.aluOp));
      checkOutput("bp_we_br", 32'(weBr), 32'(heldExp.weBr));
      checkOutput("bp_pc", 32'(pc), 32'd1);
      checkOutput("bp_cnt", 32'(issuedCnt), 32'd0);
    end
    outReady = 1'b1;
    waitCycles(1);
    checkOutput("bp_release_cnt", 32'(issuedCnt), 32'd1);
    checkOutput("bp_release_valid", 32'(outValid), 32'd0);
    checkOutput("bp_release_addr", 32'(imemAddr), 32'd1);
    waitCycles(1);
    checkOutput("bp_single_inc", 32'(issuedCnt), 32'd1);
    k = 0;
    while (!done && k < 20) begin
      waitCycles(1);
      k++;
    end
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_cnt", 32'(issuedCnt), 32'd2);
    checkOutput("t2_pc", 32'(pc), 32'd2);
    checkOutput("t2_handshakes", 32'(hsCount), 32'd3);
    checkOutput("t2_sb_empty", 32'(sbQueue.size()), 32'd0);

    // Asynchronous reset while an instruction is being offered
    rom[0] = 16'h0123;
    outReady = 1'b0;
    sbQueue.push_back(modelDecode(16'h0123));
    applyStimulus(1'b0);
    waitCycles(2);
    checkOutput("ar_pre_valid", 32'(outValid), 32'd1);
    checkOutput("ar_pre_pc", 32'(pc), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 32'(outValid), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_pc", 32'(pc), 32'd0);
    checkOutput("ar_cnt", 32'(issuedCnt), 32'd0);
    checkOutput("ar_op1", 32'(op1), 32'd0);
    checkOutput("ar_done", 32'(done), 32'd0);
    sbQueue.delete();
    waitCycles(1);
    rst = 1'b0;
    outReady = 1'b1;
    waitCycles(4);
    checkOutput("ar_idle_busy", 32'(busy), 32'd0);
    checkOutput("ar_idle_rd", 32'(imemRd), 32'd0);
    checkOutput("ar_idle_pc", 32'(pc), 32'd0);
    checkOutput("ar_idle_hs", 32'(hsCount), 32'd3);

    // Wrap-around on the 2-bit address instance
    romW[0] = 16'h0021;
    romW[1] = 16'h5CA9;
    romW[2] = 16'h1885;
    romW[3] = 16'h3C07;
    outReadyW = 1'b1;
    applyStimulus(1'b1);
    for (int j = 0; j < 6; j++) begin
      wrapExp = modelDecode(romW[j % 4]);
      checkOutput("wr_fetch_rd", 32'(imemRdW), 32'd1);
      checkOutput("wr_fetch_addr", 32'(imemAddrW), 32'(j % 4));
      waitCycles(2);
      checkOutput("wr_valid", 32'(outValidW), 32'd1);
      checkOutput("wr_pc", 32'(pcW), 32'((j + 1) % 4));
      checkOutput("wr_op1", 32'(op1W), 32'(wrapExp.op1));
      checkOutput("wr_op2", 32'(op2W), 32'(wrapExp.op2));
      checkOutput("wr_alu_op", 32'(aluOpW), 32'(wrapExp.aluOp));
      checkOutput("wr_we_br", 32'(weBrW), 32'(wrapExp.weBr));
      waitCycles(1);
    end
    checkOutput("wr_cnt", 32'(issuedCntW), 32'd6);
    checkOutput("wr_done", 32'(doneW), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
